matmul_stream: RTL and testbench

//  Parametrised NxN matrix multiplier C = A x B for the CA matrix-engine family.
//  A and B stream in row-major order over a valid/ready input port; each C element streams out row-major over a valid/ready output port.

---
 rtl/matmul_stream.sv | 193 +++++++++++++++++++
 tb/tb_matmul_stream.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/matmul_stream.sv
// matmul_stream: streaming NxN matrix multiplier C = A x B.
// A then B arrive row-major over a valid/ready input; each C element is
// produced by N MAC cycles and leaves row-major over a valid/ready output.
// One multiplier, operands held in register arrays, optional saturation.
module matmul_stream #(
    parameter int N      = 3,
    parameter int DATA_W = 8,
    parameter int OUT_W  = 8,
    parameter int SAT    = 1,
    parameter int ACC_W  = 2*DATA_W + $clog2(N) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OUT_W-1:0]  data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int IW = $clog2(N);
    localparam int AW = $clog2(N*N);
    localparam int PW = 2*DATA_W + 2;

    localparam logic [IW-1:0] LAST = IW'(N-1);
    localparam logic [IW-1:0] ONE  = IW'(1);
    localparam logic [AW-1:0] NA   = AW'(N);

    // Clamp bounds expressed at accumulator width so compares stay signed.
    localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] UMAX = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        COMPUTE = 3'd3,
        OUT     = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t state;

    logic [N*N-1:0][DATA_W-1:0] a_mem;
    logic [N*N-1:0][DATA_W-1:0] b_mem;

    logic [IW-1:0] ld_r, ld_c;
    logic [IW-1:0] ri, cj, kk;
    logic          sgn;
    logic signed [ACC_W-1:0] acc;

    logic          beat;
    logic          ld_last;
    logic [AW-1:0] ld_addr, a_addr, b_addr;

    logic [DATA_W-1:0]        a_op, b_op;
    logic signed [DATA_W:0]   a_ext, b_ext;
    logic signed [PW-1:0]     a_wide, b_wide, prod;
    logic signed [ACC_W-1:0]  acc_base, acc_add, acc_next;
    logic [OUT_W-1:0]         acc_red;

    assign beat    = in_valid & in_ready;
    assign ld_last = (ld_r == LAST) && (ld_c == LAST);
    assign ld_addr = AW'(ld_r) * NA + AW'(ld_c);
    assign a_addr  = AW'(ri) * NA + AW'(kk);
    assign b_addr  = AW'(kk) * NA + AW'(cj);

    // MAC datapath: extend by one bit so unsigned and signed share a signed multiply
    assign a_op     = a_mem[a_addr];
    assign b_op     = b_mem[b_addr];
    assign a_ext    = signed'({sgn & a_op[DATA_W-1], a_op});
    assign b_ext    = signed'({sgn & b_op[DATA_W-1], b_op});
    assign a_wide   = PW'(a_ext);
    assign b_wide   = PW'(b_ext);
    assign prod     = a_wide * b_wide;
    assign acc_add  = ACC_W'(prod);
    assign acc_base = (kk == '0) ? '0 : acc;
    assign acc_next = acc_base + acc_add;

    // Reduce the finished dot product to OUT_W: clamp or truncate
    always_comb begin
        acc_red = acc_next[OUT_W-1:0];
        if (SAT != 0) begin
            if (sgn) begin
                if (acc_next > SMAX)      acc_red = SMAX[OUT_W-1:0];
                else if (acc_next < SMIN) acc_red = SMIN[OUT_W-1:0];
            end else if (acc_next > UMAX) begin
                acc_red = UMAX[OUT_W-1:0];
            end
        end
    end

    // Operand storage: written only on load beats, never cleared
    always_ff @(posedge clk) begin
        if (rst && beat && state == LOAD_A) a_mem[ld_addr] <= data_in;
        if (rst && beat && state == LOAD_B) b_mem[ld_addr] <= data_in;
    end

    // Control FSM with registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            ld_r      <= '0;
            ld_c      <= '0;
            ri        <= '0;
            cj        <= '0;
            kk        <= '0;
            acc       <= '0;
            sgn       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sgn      <= signed_mode;
                        state    <= LOAD_A;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        ld_r     <= '0;
                        ld_c     <= '0;
                    end
                end
                LOAD_A, LOAD_B: begin
                    if (beat) begin
                        if (ld_last) begin
                            ld_r <= '0;
                            ld_c <= '0;
                            if (state == LOAD_A) begin
                                state <= LOAD_B;
                            end else begin
                                state    <= COMPUTE;
                                in_ready <= 1'b0;
                                ri       <= '0;
                                cj       <= '0;
                                kk       <= '0;
                            end
                        end else if (ld_c == LAST) begin
                            ld_c <= '0;
                            ld_r <= ld_r + ONE;
                        end else begin
                            ld_c <= ld_c + ONE;
                        end
                    end
                end
                COMPUTE: begin
                    acc <= acc_next;
                    if (kk == LAST) begin
                        kk        <= '0;
                        state     <= OUT;
                        out_valid <= 1'b1;
                        data_out  <= acc_red;
                    end else begin
                        kk <= kk + ONE;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (ri == LAST && cj == LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= COMPUTE;
                            if (cj == LAST) begin
                                cj <= '0;
                                ri <= ri + ONE;
                            end else begin
                                cj <= cj + ONE;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_stream.sv
// tb_matmul_stream: directed vectors for the 3x3 multiplier, checked against
// hand-computed C matrices. A second instance with truncation runs in lockstep.
module tb_matmul_stream;

    logic       clk = 1'b0;
    logic       rst, start, signed_mode, in_valid, out_ready;
    logic [7:0] data_in;
    logic       in_ready, out_valid, busy, done;
    logic [7:0] data_out;
    logic       in_ready0, out_valid0, busy0, done0;
    logic [7:0] data_out0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    matmul_stream #(.N(3), .DATA_W(8), .OUT_W(8), .SAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
        .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    matmul_stream #(.N(3), .DATA_W(8), .OUT_W(8), .SAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready0),
        .data_out(data_out0), .out_valid(out_valid0), .out_ready(out_ready),
        .busy(busy0), .done(done0)
    );

    typedef struct {
        logic [8:0][7:0] a;
        logic [8:0][7:0] b;
        logic [8:0][7:0] exp;
        logic [8:0][7:0] exp0;
        logic            sgn;
        logic            gap;
        logic            stall;
    } vec_t;

    vec_t tv[7];

    function automatic logic [8:0][7:0] mk(input int v0, input int v1, input int v2,
                                           input int v3, input int v4, input int v5,
                                           input int v6, input int v7, input int v8);
        logic [8:0][7:0] m;
        m[0] = 8'(v0); m[1] = 8'(v1); m[2] = 8'(v2);
        m[3] = 8'(v3); m[4] = 8'(v4); m[5] = 8'(v5);
        m[6] = 8'(v6); m[7] = 8'(v7); m[8] = 8'(v8);
        return m;
    endfunction

    function automatic logic [8:0][7:0] mkall(input int v);
        return mk(v, v, v, v, v, v, v, v, v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic load_mat(input logic [8:0][7:0] m, input logic gap);
        for (int e = 0; e < 9; e++) begin
            if (gap) begin
                in_valid = 1'b0;
                data_in  = 8'hA5;
                @(posedge clk); #1;
            end
            if (e == 0) chk("in_ready_load", in_ready, 1);
            data_in  = m[e];
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_job(input int t);
        vec_t v;
        int   n;
        logic [7:0] held;
        v = tv[t];
        chk("idle_busy", busy, 0);
        chk("idle_in_ready", in_ready, 0);
        signed_mode = v.sgn;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        load_mat(v.a, v.gap);
        load_mat(v.b, v.gap);
        for (int e = 0; e < 9; e++) begin
            n = 0;
            if (e == 0) start = 1'b1;
            while (!out_valid && n < 20) begin
                @(posedge clk); #1;
                start = 1'b0;
                n++;
            end
            start = 1'b0;
            chk($sformatf("latency[%0d.%0d]", t, e), n, 3);
            chk("in_ready_out", in_ready, 0);
            if (v.stall && e == 4) begin
                out_ready = 1'b0;
                held = data_out;
                repeat (5) begin
                    @(posedge clk); #1;
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", data_out, held);
                end
                out_ready = 1'b1;
            end
            chk($sformatf("c_sat[%0d.%0d]", t, e), data_out, v.exp[e]);
            chk($sformatf("c_trunc[%0d.%0d]", t, e), data_out0, v.exp0[e]);
            @(posedge clk); #1;
        end
        chk("done_pulse", done, 1);
        chk("done_out_valid", out_valid, 0);
        chk("done_busy", busy, 1);
        @(posedge clk); #1;
        chk("done_clear", done, 0);
        chk("busy_clear", busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; start = 1'b0; signed_mode = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; data_in = '0;

        tv[0] = '{a: mk(1,0,0, 0,1,0, 0,0,1), b: mk(1,2,3,4,5,6,7,8,9),
                  exp: mk(1,2,3,4,5,6,7,8,9), exp0: mk(1,2,3,4,5,6,7,8,9),
                  sgn: 1'b0, gap: 1'b0, stall: 1'b0};
        tv[1] = '{a: mkall(255), b: mkall(255), exp: mkall(255), exp0: mkall(3),
                  sgn: 1'b0, gap: 1'b0, stall: 1'b1};
        tv[2] = '{a: mkall(128), b: mkall(128), exp: mkall(127), exp0: mkall(0),
                  sgn: 1'b1, gap: 1'b0, stall: 1'b0};
        tv[3] = '{a: mk(255,0,0, 0,2,0, 0,0,253), b: mk(1,0,0, 0,1,0, 0,0,1),
                  exp: mk(255,0,0, 0,2,0, 0,0,253), exp0: mk(255,0,0, 0,2,0, 0,0,253),
                  sgn: 1'b1, gap: 1'b0, stall: 1'b0};
        tv[4] = '{a: mk(1,2,3,4,5,6,7,8,9), b: mk(1,1,0, 0,1,1, 1,0,1),
                  exp: mk(4,3,5, 10,9,11, 16,15,17), exp0: mk(4,3,5, 10,9,11, 16,15,17),
                  sgn: 1'b0, gap: 1'b0, stall: 1'b0};
        tv[5] = tv[4];
        tv[5].gap   = 1'b1;
        tv[5].stall = 1'b1;
        tv[6] = '{a: mkall(128), b: mkall(127), exp: mkall(128), exp0: mkall(128),
                  sgn: 1'b1, gap: 1'b0, stall: 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 7; t++) run_job(t);

        // Abort a job part-way through loading B, then run a clean job.
        signed_mode = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        load_mat(tv[0].a, 1'b0);
        for (int e = 0; e < 3; e++) begin
            data_in  = tv[0].b[e];
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("midb_in_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midb_rst_in_ready", in_ready, 0);
        chk("midb_rst_out_valid", out_valid, 0);
        chk("midb_rst_data_out", data_out, 0);
        chk("midb_rst_busy", busy, 0);
        chk("midb_rst_done", done, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        run_job(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
